// File: rtl/piso_pkg.sv
`default_nettype none
// piso_pkg: shared state encoding and counter-width helpers for piso_serializer.
package piso_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  function automatic int bit_cnt_width(input int width);
    return ($clog2(width) > 1) ? $clog2(width) : 1;
  endfunction

  function automatic int gap_cnt_width(input int gap);
    return ($clog2(gap + 1) > 1) ? $clog2(gap + 1) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/piso_gap_counter.sv
`default_nettype none
// piso_gap_counter: load/decrement idle-gap counter, done while the count is zero.
module piso_gap_counter #(
  parameter int CW = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          dec,
  output logic          done
);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (dec && (count != '0))
      count <= count - 1'b1;
  end

  assign done = (count == '0);

endmodule
`default_nettype wire

// File: rtl/piso_serializer.sv
`default_nettype none
// piso_serializer: valid/ready parallel word in, one registered bit per clock out,
// with frame-start strobe and optional idle gap between words.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int GAP_CYCLES = 0,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             serial_out,
  output logic             bit_valid,
  output logic             frame_start,
  output logic             busy
);

  localparam int            BW       = bit_cnt_width(WIDTH);
  localparam logic [BW-1:0] LAST_IDX = BW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [BW-1:0]    bit_cnt;
  logic             last_bit;
  logic             accept;
  logic             gap_done;

  assign last_bit = (state == SHIFT) && (bit_cnt == '0);
  // With no gap the next word may be taken on the last bit, giving a bubble-free stream.
  assign in_ready = !rst && ((state == IDLE) || ((GAP_CYCLES == 0) && last_bit));
  assign accept   = in_valid && in_ready;
  assign busy     = (state != IDLE);

  generate
    if (GAP_CYCLES > 0) begin : g_gap
      localparam int GW = gap_cnt_width(GAP_CYCLES);
      piso_gap_counter #(.CW(GW)) u_gap_counter (
        .clk     (clk),
        .rst     (rst),
        .load    (last_bit),
        .load_val(GW'(GAP_CYCLES - 1)),
        .dec     (state == GAP),
        .done    (gap_done)
      );
    end else begin : g_no_gap
      assign gap_done = 1'b1;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      shreg       <= '0;
      bit_cnt     <= '0;
      serial_out  <= 1'b0;
      bit_valid   <= 1'b0;
      frame_start <= 1'b0;
    end else if (accept) begin
      state       <= SHIFT;
      shreg       <= in_data;
      bit_cnt     <= LAST_IDX;
      serial_out  <= MSB_FIRST ? in_data[WIDTH-1] : in_data[0];
      bit_valid   <= 1'b1;
      frame_start <= 1'b1;
    end else begin
      frame_start <= 1'b0;
      case (state)
        SHIFT: begin
          if (bit_cnt != '0) begin
            shreg      <= MSB_FIRST ? (shreg << 1) : (shreg >> 1);
            bit_cnt    <= bit_cnt - 1'b1;
            serial_out <= MSB_FIRST ? shreg[WIDTH-2] : shreg[1];
            bit_valid  <= 1'b1;
          end else begin
            state      <= (GAP_CYCLES != 0) ? GAP : IDLE;
            serial_out <= 1'b0;
            bit_valid  <= 1'b0;
          end
        end
        GAP: begin
          if (gap_done)
            state <= IDLE;
          serial_out <= 1'b0;
          bit_valid  <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          serial_out <= 1'b0;
          bit_valid  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_piso_serializer.sv
`default_nettype none
// tb_piso_serializer: three configurations checked every cycle against a queue model
// of the expected line, plus directed literal checks and a 3-flop SISO stage.
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] din [3];
  logic       vin [3];
  logic       so [3];
  logic       bv [3];
  logic       fs [3];
  logic       rdy [3];
  logic       bsy [3];
  logic [2:0] siso;
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic [1:0] cap [3][$];   // {frame_start, serial_out} of each valid bit
  int         capc [3][$];  // cycle stamp of each captured bit

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (rst) siso <= 3'b000;
    else     siso <= {siso[1:0], so[0]};
  end

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (bv[k] === 1'b1) begin
        cap[k].push_back({fs[k], so[k]});
        capc[k].push_back(cyc);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, exp);
    end
  endtask

  for (genvar k = 0; k < 3; k++) begin : g_cfg
    localparam int G = (k == 1) ? 2 : 0;
    localparam bit M = (k == 2) ? 1'b0 : 1'b1;
    logic [2:0] q [$];  // expected {bit_valid, frame_start, serial_out}, one entry per cycle

    piso_serializer #(.WIDTH(8), .GAP_CYCLES(G), .MSB_FIRST(M)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .in_data    (din[k]),
      .in_valid   (vin[k]),
      .in_ready   (rdy[k]),
      .serial_out (so[k]),
      .bit_valid  (bv[k]),
      .frame_start(fs[k]),
      .busy       (bsy[k])
    );

    always @(posedge clk) begin
      logic acc;
      acc = !rst && vin[k] && ((q.size() == 0) || ((G == 0) && (q.size() == 1)));
      if (rst) begin
        q.delete();
      end else begin
        if (q.size() != 0) void'(q.pop_front());
        if (acc) begin
          for (int i = 0; i < 8; i++)
            q.push_back({1'b1, (i == 0), (M ? din[k][7-i] : din[k][i])});
          for (int g = 0; g < G; g++)
            q.push_back(3'b000);
        end
      end
    end

    always @(negedge clk) begin
      logic [2:0] e;
      logic       er;
      e  = (q.size() != 0) ? q[0] : 3'b000;
      er = !rst && ((q.size() == 0) || ((G == 0) && (q.size() == 1)));
      check($sformatf("cfg%0d line{bv,fs,so,rdy,busy}", k),
            {27'd0, bv[k], fs[k], so[k], rdy[k], bsy[k]},
            {27'd0, e, er, (q.size() != 0)});
    end
  end

  task automatic send(input int k, input logic [7:0] d);
    int n;
    n      = 0;
    vin[k] = 1'b1;
    din[k] = d;
    @(negedge clk);
    while (rdy[k] !== 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (rdy[k] !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL send_timeout cfg%0d got ready=%b want ready=1 within 100 cycles", k, rdy[k]);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rand_drive(input int k);
    for (int n = 0; n < 60; n++) begin
      vin[k] = 1'b0;
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      send(k, 8'($urandom));
    end
    vin[k] = 1'b0;
  endtask

  task automatic clear_cap(input int k);
    cap[k].delete();
    capc[k].delete();
  endtask

  function automatic logic [15:0] pack(input int k, input int sel);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 16 && i < cap[k].size(); i++) r[15-i] = cap[k][i][sel];
    return r;
  endfunction

  function automatic int span(input int k, input int a, input int b);
    if (b >= capc[k].size()) return -1;
    return capc[k][b] - capc[k][a];
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] word, sw, fsv;
    word = '0; sw = '0; fsv = '0;
    for (int k = 0; k < 3; k++) begin
      vin[k] = 1'b0;
      din[k] = 8'h00;
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset outputs", {bv[0], fs[0], so[0], bsy[0]}, 0);
    check("ready during reset", rdy[0], 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("ready after reset", rdy[0], 1);
    @(posedge clk); #1;

    // Single word, MSB first, with the SISO stage on the line
    send(0, 8'hA5);
    vin[0] = 1'b0;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      if (i < 8) begin
        word[7-i] = so[0];
        fsv[7-i]  = fs[0];
      end
      if (i >= 3) sw[10-i] = siso[2];
      if (i == 7) check("t1 ready on last bit", rdy[0], 1);
      if (i == 8) check("t1 idle after word", {bv[0], so[0], bsy[0]}, 0);
    end
    check("t1 bits", word, 8'hA5);
    check("t1 frame", fsv, 8'h80);
    check("t6 siso delayed 3", sw, 8'hA5);
    @(posedge clk); #1;

    // Back-to-back words, no bubble
    clear_cap(0);
    send(0, 8'hA5);
    send(0, 8'h3C);
    vin[0] = 1'b0;
    repeat (12) @(negedge clk);
    check("t2 count", cap[0].size(), 16);
    check("t2 bits", pack(0, 0), 16'hA53C);
    check("t2 frame", pack(0, 1), 16'h8080);
    check("t2 contiguous", span(0, 0, 15), 15);
    @(posedge clk); #1;

    // Two-cycle gap
    clear_cap(1);
    send(1, 8'hFF);
    send(1, 8'h00);
    vin[1] = 1'b0;
    repeat (14) @(negedge clk);
    check("t3 count", cap[1].size(), 16);
    check("t3 bits", pack(1, 0), 16'hFF00);
    check("t3 frame", pack(1, 1), 16'h8080);
    check("t3 word span", span(1, 0, 7), 7);
    check("t3 second word start", span(1, 0, 8), 11);
    @(posedge clk); #1;

    // LSB first
    clear_cap(2);
    send(2, 8'h01);
    vin[2] = 1'b0;
    repeat (10) @(negedge clk);
    check("t4 count", cap[2].size(), 8);
    check("t4 bits", pack(2, 0), 16'h8000);
    check("t4 frame", pack(2, 1), 16'h8000);
    @(posedge clk); #1;

    // Reset after three bits
    clear_cap(0);
    send(0, 8'hA5);
    vin[0] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("t5 after reset", {bv[0], so[0], bsy[0]}, 0);
    check("t5 ready after reset", rdy[0], 1);
    check("t5 partial count", cap[0].size(), 3);
    check("t5 partial bits", pack(0, 0), 16'hA000);
    @(posedge clk); #1;
    clear_cap(0);
    send(0, 8'h3C);
    vin[0] = 1'b0;
    repeat (10) @(negedge clk);
    check("t5 count", cap[0].size(), 8);
    check("t5 bits", pack(0, 0), 16'h3C00);
    check("t5 frame", pack(0, 1), 16'h8000);

    // Randomized traffic on all configurations with occasional resets
    @(posedge clk); #1;
    fork
      rand_drive(0);
      rand_drive(1);
      rand_drive(2);
      begin
        repeat (4) begin
          repeat ($urandom_range(100, 250)) @(posedge clk);
          #1 rst = 1'b1;
          @(posedge clk);
          #1 rst = 1'b0;
        end
      end
    join
    repeat (20) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
Parallel-in serial-out serializer that sits directly upstream of the team's 3-bit SISO shift-register stage. It accepts a WIDTH-bit word over a valid/ready handshake and drives it one bit per clock onto a serial line, which connects to the SISO stage's serial input. A qualifier strobe marks valid bits, and a frame-start strobe marks the first bit of each word. An optional programmable idle gap separates consecutive words.

Parameters:
WIDTH, 8, word width in bits; legal range is 2 or more.
GAP_CYCLES, 0, number of idle cycles (bit_valid low) inserted after the last bit of every word; legal range is 0 or more.
MSB_FIRST, 1, 1 = transmit bit WIDTH-1 first; 0 = transmit bit 0 first.

Ports:
clk  input  1  clock; all logic on the rising edge
rst  input  1  reset, synchronous, active-high
in_data  input  WIDTH  parallel word to serialize
in_valid  input  1  in_data is valid
in_ready  output  1  block can accept a word this cycle
serial_out  output  1  serial bit stream (feeds the SISO serial_in)
bit_valid  output  1  serial_out carries a data bit this cycle
frame_start  output  1  high for the first bit of each word only
busy  output  1  a word is in flight or a gap is being counted

Behaviour:
- State machine has three states: IDLE, SHIFT, GAP.
- serial_out, bit_valid and frame_start are registered. in_ready is combinational from state and counters.
- Reset (rst high at an edge):
  - state <= IDLE; shift register, bit counter and gap counter <= 0.
  - serial_out, bit_valid, frame_start and busy are 0 in the cycle after the edge.
  - in_ready is forced to 0 in any cycle where rst is high.
- Reset mid-word or mid-gap: the partial word is discarded and no further bits are emitted. The next cycle is IDLE with all outputs 0.
- Accept condition: in_valid && in_ready at a rising edge.
  - in_ready is 1 in IDLE.
  - in_ready is also 1 in SHIFT on the last bit cycle when GAP_CYCLES == 0.
  - in_ready is 0 at all other times.
- Accept at edge N:
  - in_data is loaded into the shift register and the bit counter is set to WIDTH-1.
  - The state moves to SHIFT.
  - In cycle N+1, serial_out holds the first bit, with bit_valid=1 and frame_start=1.
  - In cycles N+2 through N+WIDTH, the remaining bits are sent one per cycle, with bit_valid=1 and frame_start=0.
  - Latency from accept to first bit is 1 cycle. A word occupies exactly WIDTH bit cycles.
- Bit order: MSB_FIRST=1 shifts left and emits bit[WIDTH-1] first. MSB_FIRST=0 shifts right and emits bit[0] first.
- End of word (bit counter = 0 in SHIFT):
  - If GAP_CYCLES = 0 and a word is accepted that same edge, the next word starts with no bubble (its first bit is in cycle N+WIDTH+1).
  - If GAP_CYCLES = 0 and no word is accepted, the state goes to IDLE.
  - If GAP_CYCLES > 0, the state goes to GAP for exactly GAP_CYCLES cycles, then to IDLE. No word is accepted during GAP.
- Whenever bit_valid = 0, serial_out is driven 0. The line never carries stale data.
- busy = (state != IDLE).
- Counter widths: the bit counter is $clog2(WIDTH) bits; the gap counter is $clog2(GAP_CYCLES+1) bits, with a minimum of 1. Neither counter wraps: each is reloaded on entry to its state.
- If in_valid is high while in_ready is low, the word is not consumed. The upstream must hold in_data stable until accepted, and the block samples in_data only on the accept edge.
- Simultaneous rst and accept: rst wins and nothing is loaded.

Decomposition:
- Shared package piso_pkg holds:
  - the state typedef (IDLE, SHIFT, GAP);
  - localparam helper functions for the counter widths.
- One natural sub-module: piso_gap_counter. It is a load/decrement counter that asserts done at zero; it is instantiated only when GAP_CYCLES > 0.
- The shift datapath and FSM stay in the top module.

Test Plan:
1. WIDTH=8, MSB_FIRST=1, GAP=0; accept 0xA5 at edge N -> serial_out 1,0,1,0,0,1,0,1 in cycles N+1..N+8; frame_start only at N+1; in_ready=1 at N+8; bit_valid=0 and busy=0 at N+9.
2. Back-to-back: in_valid held with 0xA5 then 0x3C -> 16 contiguous valid bits 10100101 00111100; frame_start at N+1 and N+9; no bubble.
3. GAP_CYCLES=2: two words 0xFF, 0x00 -> 8 ones, then 2 cycles with bit_valid=0 and serial_out=0, then in_ready=1; the second word's first bit comes no earlier than 11 cycles after the first accept.
4. MSB_FIRST=0; accept 0x01 -> serial_out 1 then seven 0s.
5. Reset mid-word: accept 0xA5, assert rst after 3 bits -> next cycle bit_valid=0, serial_out=0, busy=0; after release, accepting 0x3C streams 00111100 cleanly.
6. Integration: drive serial_out into the 3-bit SISO stage -> its serial_out reproduces 0xA5's bit sequence delayed by exactly 3 cycles.
